// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory, pipeline-control and IF/ID latch signals of the fetch stage
interface fetch_stage_if;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] instr_ID;
  logic [31:0] imemaddr_ID;
  logic [31:0] npc_ID;
  logic        valid_ID;
  logic [31:0] fetch_count;
  modport master (
    input  ihit, imemload, stall, flush, redirect, redirect_pc, halt,
    output imemREN, imemaddr, instr_ID, imemaddr_ID, npc_ID, valid_ID, fetch_count
  );
  modport slave (
    output ihit, imemload, stall, flush, redirect, redirect_pc, halt,
    input  imemREN, imemaddr, instr_ID, imemaddr_ID, npc_ID, valid_ID, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction-memory request and IF/ID latch with redirect draining and halt
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input logic          CLK,
  input logic          RST,
  fetch_stage_if.master bus
);
  typedef enum logic [1:0] {S_FETCH, S_DRAIN, S_HALTED} state_t;
  state_t      r_state, w_state;
  logic [31:0] r_pc, w_pc, r_pend, w_pend, w_rpc;
  logic [31:0] r_instr, r_addr_id, r_npc_id, r_count;
  logic        r_valid, w_load, w_bub;
  assign w_rpc            = bus.redirect_pc & ~32'h3;
  assign bus.imemaddr     = r_pc;
  assign bus.imemREN      = (r_state != S_HALTED) & !RST;
  assign bus.instr_ID     = r_instr;
  assign bus.imemaddr_ID  = r_addr_id;
  assign bus.npc_ID       = r_npc_id;
  assign bus.valid_ID     = r_valid;
  assign bus.fetch_count  = r_count;
  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_pend  = r_pend;
    w_load  = 1'b0;
    w_bub   = 1'b0;
    if (r_state == S_HALTED) begin
      w_bub = 1'b1;
    end else if (bus.halt) begin
      w_state = S_HALTED;
      w_bub   = 1'b1;
    end else if (r_state == S_FETCH) begin
      if (bus.redirect) begin
        w_bub = 1'b1;
        if (bus.ihit) w_pc = w_rpc;
        else begin
          w_pend  = w_rpc;
          w_state = S_DRAIN;
        end
      end else if (!bus.stall) begin
        w_load = bus.ihit;
        w_bub  = !bus.ihit;
        w_pc   = bus.ihit ? r_pc + 32'd4 : r_pc;
      end
    end else begin
      // the outstanding access completes at the old PC; its word is discarded
      w_bub  = !bus.stall;
      w_pend = bus.redirect ? w_rpc : r_pend;
      if (bus.ihit) begin
        w_pc    = bus.redirect ? w_rpc : r_pend;
        w_state = S_FETCH;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_FETCH;
      r_pc      <= PC_INIT;
      r_pend    <= '0;
      r_instr   <= '0;
      r_addr_id <= '0;
      r_npc_id  <= '0;
      r_valid   <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_pend  <= w_pend;
      if (w_bub || bus.flush) begin
        r_instr   <= '0;
        r_addr_id <= '0;
        r_npc_id  <= '0;
        r_valid   <= 1'b0;
      end else if (w_load) begin
        r_instr   <= bus.imemload;
        r_addr_id <= r_pc;
        r_npc_id  <= r_pc + 32'd4;
        r_valid   <= 1'b1;
        r_count   <= r_count + 32'd1;
      end
    end
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core: owns the program counter, drives the instruction-memory request, and loads the IF/ID pipeline latch that feeds the decode stage. It sits directly upstream of decode, producing `instr_ID` and `imemaddr_ID`, which the decode stage and the ID/EX latch consume. It absorbs redirects (branch/jump) from later stages, including redirects that arrive while an instruction-memory access is still outstanding. It also honours stall, flush and halt requests from the hazard unit and later stages.

## Interface
Parameters:
- `PC_INIT`, 32'h0000_0000, PC value loaded on reset (word aligned)

Ports:
- `CLK`  in  1  clock, all state updates on rising edge
- `RST`  in  1  synchronous, active-high reset
- `ihit`  in  1  instruction memory returns `imemload` for `imemaddr` this cycle
- `imemload`  in  32  instruction word from memory
- `imemREN`  out  1  instruction read request
- `imemaddr`  out  32  instruction fetch address (current PC)
- `stall`  in  1  hold PC and IF/ID latch (from hazard unit)
- `flush`  in  1  force IF/ID latch to bubble
- `redirect`  in  1  taken branch/jump; refetch from `redirect_pc`
- `redirect_pc`  in  32  redirect target
- `halt`  in  1  halt reached later in pipe; stop fetching
- `instr_ID`  out  32  latched instruction
- `imemaddr_ID`  out  32  PC of latched instruction
- `npc_ID`  out  32  `imemaddr_ID` + 4
- `valid_ID`  out  1  latch holds a real instruction (0 = bubble)
- `fetch_count`  out  32  count of instructions accepted into IF/ID

## Operation
- State machine: FETCH, DRAIN, HALTED.
- Priority each cycle: RST > halt > redirect > stall > normal advance.
- FETCH, no redirect/halt: if `ihit` and not `stall`: PC <= PC+4, latch loads {`imemload`, PC, PC+4, valid=1}, `fetch_count`++. If not `ihit` and not `stall`: latch loads bubble, PC holds.
- FETCH, `stall`: PC holds, latch holds (fetched word dropped; refetched later).
- FETCH, `redirect` with `ihit`: PC <= `redirect_pc`, latch bubble, stay FETCH.
- FETCH, `redirect` without `ihit`: pending <= `redirect_pc`, latch bubble, go DRAIN (outstanding access must complete at unchanged address).
- DRAIN: `imemaddr` holds old PC; latch bubble unless `stall` (then holds). New `redirect` overwrites pending. On `ihit`: returned word discarded, PC <= pending (or `redirect_pc` if `redirect` same cycle), go FETCH.
- `halt` (any state): go HALTED, latch bubble. HALTED: `imemREN`=0, PC frozen, latch bubble; exit only via RST.
- `flush`: latch loads bubble regardless of `stall`; does not affect PC or state.
- Bubble = instr 0, `imemaddr_ID` 0, `npc_ID` 0, valid 0.
- Arithmetic: PC+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0). `redirect_pc[1:0]` ignored, forced to 00. `fetch_count` wraps at 2^32.

## Timing
- Reset values: PC=`PC_INIT`, state FETCH, pending 0, all latch outputs 0, `valid_ID` 0, `fetch_count` 0; `imemREN`=0 while `RST` high.
- `imemaddr` = PC register (no combinational path from inputs); `imemREN` = (state != HALTED) & !RST.
- Latency: word returned with `ihit` in cycle N appears on `instr_ID` in cycle N+1.
- Handshake: `imemaddr` stable from request until `ihit` (guaranteed by DRAIN).
- Redirect penalty: target fetched starting the cycle after redirect (FETCH+ihit) or after drain `ihit`.
- RST mid-DRAIN: pending discarded, refetch from `PC_INIT`.

## Test plan
- Reset then `ihit`=1 constantly, memory returns addr-as-data: `imemaddr` 0,4,8; `instr_ID` 0,4,8 one cycle later; `fetch_count`=3 after 3 hits.
- `stall` 2 cycles at PC=8 with `ihit`=1: PC stays 8, `instr_ID` holds 4, no count increment; resumes with 8.
- `redirect` to 0x100 with `ihit`=1: next `imemaddr`=0x100, `valid_ID`=0 next cycle.
- `redirect` to 0x200 with `ihit`=0, then 0x300 in DRAIN, `ihit` 3 cycles later: `imemaddr` holds old PC throughout, returned word never valid, then `imemaddr`=0x300.
- `flush`+`stall` together: `valid_ID`=0, PC unchanged.
- `halt` at PC=0x20: `imemREN`=0 next cycle, PC frozen, `valid_ID`=0; `RST` restores PC=`PC_INIT`, FETCH.
